// File: rtl/uart_pkg.sv
// uart_pkg
// Types and helpers shared by the UART transmitter and the future receiver.
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN : encodings of the PARITY parameter
//   uart_state_t                  : frame state enum (IDLE, START, DATA, PARITY, STOP)
//   clks_per_bit()                : clocks per bit, truncated integer divide
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Restartable bit-period divider. The counter runs 0..CLKS_PER_BIT-1 and
// wraps; tick is high during the last clock of each bit period.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  synchronous reset, active-low
//   restart in  forces the counter back to 0 on the next edge
//   tick    out high in the final cycle of a bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Bit timer: restart wins over the natural wrap so a new frame always
    // begins a fresh, full-length bit period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick must not be masked by restart: the transmitter derives restart
    // from tick at the end of a frame when chaining back-to-back words.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter with a one-word holding buffer, so a producer
// can hand over the next word while the current frame is still shifting out.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each bit lasts CLK_FREQ / BAUD_RATE clocks.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous reset, active-low (aborts any frame)
//   tx_data  in  word to send
//   tx_valid in  producer has a word
//   tx_ready out holding buffer empty; transfer when tx_valid && tx_ready
//   tx       out serial line, idles high (registered)
//   busy     out frame in progress or word pending (registered)
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int               IDX_W        = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA    = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP    = IDX_W'(STOP_BITS - 1);
    localparam bit               HAS_PARITY   = (PARITY != PAR_NONE);

    // Reject illegal frame formats at elaboration rather than producing
    // a transmitter with silently wrong timing.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_param: CLK_FREQ / BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_d;
    logic                 load;
    logic                 tick;
    logic                 restart;

    // Keeping the timer parked at 0 while idle means a load always starts
    // a full start bit; the explicit restart on load covers the chained case.
    assign restart = load || (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state logic. bit_idx counts data bits in DATA and stop bits in
    // STOP. A load out of the last stop cycle jumps straight to START so
    // back-to-back frames have no idle gap. tx is computed from the next
    // state so the registered line changes on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        par_d       = par_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        tx_d        = 1'b1;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = HAS_PARITY ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Parity is fixed at load time from the whole word, before any shifting.
        if (load) begin
            state_d     = START;
            shift_d     = hold_data_q;
            bit_idx_d   = '0;
            hold_full_d = 1'b0;
            par_d       = (PARITY == PAR_ODD) ? ~(^hold_data_q) : ^hold_data_q;
        end

        // Accept only when the buffer is empty; load needs it full, so the
        // two never happen on the same edge.
        if (tx_valid && tx_ready) begin
            hold_data_d = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_d)
            START:            tx_d = 1'b0;
            DATA:             tx_d = shift_d[0];
            uart_pkg::PARITY: tx_d = par_d;
            default:          tx_d = 1'b1;
        endcase
    end

    // State and output registers. Reset drops any frame and any pending
    // word and returns the line to idle on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            par_q       <= 1'b0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            tx          <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            par_q       <= par_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            tx          <= tx_d;
            tx_ready    <= ~hold_full_d;
            busy        <= (state_d != IDLE) || hold_full_d;
        end
    end

endmodule
